// File: rtl/nn_input_feeder.sv
// Row-pair FIFO that streams N rows into the 2x2 nn input lanes.
// Lane 2 lags lane 1 by one cycle to form the systolic input diagonal.
module nn_input_feeder #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data_1,
  input  logic [DATA_W-1:0] wr_data_2,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_rows,
  output logic [DATA_W-1:0] feed_data_1,
  output logic              feed_valid_1,
  output logic [DATA_W-1:0] feed_data_2,
  output logic              feed_valid_2,
  output logic              busy,
  output logic              done,
  output logic              underflow,
  output logic [CNT_W-1:0]  occupancy
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   occ_q, occ_d, rem_q, rem_d;
  logic [DATA_W-1:0]  mem1_q [DEPTH];
  logic [DATA_W-1:0]  mem2_q [DEPTH];
  logic               push, pop, done_d, uf_d;
  logic               fv1_q, skew_v_q, fv2_q, done_q, uf_q;
  logic [DATA_W-1:0]  fd1_q, skew_q, fd2_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Full blocks writes even if a pop happens in the same cycle.
  assign wr_ready = (occ_q < CNT_W'(DEPTH));
  assign push     = wr_valid & wr_ready;

  // rem_q counts rows still to pop; row 0 is popped on the accepting edge.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    pop     = 1'b0;
    done_d  = 1'b0;
    uf_d    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (num_rows == '0)        done_d = 1'b1;
        else if (num_rows > occ_q) uf_d   = 1'b1;
        else begin
          pop     = 1'b1;
          rem_d   = num_rows - CNT_W'(1);
          state_d = FEED;
        end
      end
      FEED: if (rem_q != '0) begin
        pop   = 1'b1;
        rem_d = rem_q - CNT_W'(1);
      end else begin
        state_d = DRAIN;
      end
      DRAIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    occ_d    = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem1_q[wr_ptr_q] <= wr_data_1;
      mem2_q[wr_ptr_q] <= wr_data_2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      rem_q    <= '0;
      fv1_q    <= 1'b0;
      fd1_q    <= '0;
      skew_v_q <= 1'b0;
      skew_q   <= '0;
      fv2_q    <= 1'b0;
      fd2_q    <= '0;
      done_q   <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      rem_q    <= rem_d;
      fv1_q    <= pop;
      fd1_q    <= pop ? mem1_q[rd_ptr_q] : '0;
      // x2 waits one extra cycle in the skew register
      skew_v_q <= pop;
      skew_q   <= pop ? mem2_q[rd_ptr_q] : '0;
      fv2_q    <= skew_v_q;
      fd2_q    <= skew_v_q ? skew_q : '0;
      done_q   <= done_d;
      uf_q     <= uf_d;
    end
  end

  assign feed_valid_1 = fv1_q;
  assign feed_data_1  = fd1_q;
  assign feed_valid_2 = fv2_q;
  assign feed_data_2  = fd2_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign underflow    = uf_q;
  assign occupancy    = occ_q;

endmodule
